// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the architectural PC of the rv32i front end. It sequences req/ack
//   fetches to instruction memory, absorbs hazard stalls, applies EX-stage
//   redirects and drives the IF/ID and ID/EX flush strobes.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   imem_req/addr     fetch request and byte address (held until ack)
//   imem_ack          fetch complete; ignored while imem_req=0
//   stall             hazard hold of the front end
//   redirect_valid/pc taken branch/jump pulse and its 32-bit target
//   if_valid          fetched word accepted into IF/ID this cycle
//   cur_pc            PC of current/next fetch (pending target while draining)
//   flush_ifid/idex   pipeline squash strobes
//   misalign_err      sticky illegal-redirect flag
module pc_fetch_sequencer #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            if_valid,
  output logic [PC_W-1:0] cur_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, ERR} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic            idex_q, idex_d;
  logic            err_q, err_d;
  // Illegal redirect seen in DRAIN: wait for the outstanding ack, then ERR.
  logic            kill_q, kill_d;

  logic            rd_legal, rd_take, rd_ok, rd_bad;
  logic [PC_W-1:0] rd_tgt;

  assign rd_legal = ((redirect_pc >> PC_W) == 32'd0) && (redirect_pc[1:0] == 2'b00);
  assign rd_tgt   = redirect_pc[PC_W-1:0];
  // Redirects are ignored once dead or already committed to dying.
  assign rd_take  = redirect_valid && (state_q != ERR) && !kill_q;
  assign rd_ok    = rd_take && rd_legal;
  assign rd_bad   = rd_take && !rd_legal;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
      fcnt_q <= '0;
      idex_q <= 1'b0;
      err_q  <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      fcnt_q <= fcnt_d;
      idex_q <= idex_d;
      err_q  <= err_d;
      kill_q <= kill_d;
    end
  end

  // Next-state / next-PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    kill_d  = kill_q;
    err_d   = err_q | rd_bad;
    case (state_q)
      BOOT: begin
        // No fetch outstanding: a legal redirect lands straight in the PC.
        state_d = FETCH;
        if (rd_bad)     state_d = ERR;
        else if (rd_ok) pc_d    = rd_tgt;
      end
      FETCH: begin
        if (rd_bad) begin
          state_d = ERR;
        end else if (rd_ok) begin
          if (imem_ack) begin
            pc_d = rd_tgt;
          end else begin
            // Memory still owes us a word; hold the address until it arrives.
            pend_d  = rd_tgt;
            state_d = DRAIN;
          end
        end else if (imem_ack && !stall) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      DRAIN: begin
        if (kill_q) begin
          if (imem_ack) begin
            state_d = ERR;
            kill_d  = 1'b0;
          end
        end else if (rd_bad) begin
          if (imem_ack) state_d = ERR;
          else          kill_d  = 1'b1;
        end else if (rd_ok) begin
          if (imem_ack) begin
            pc_d    = rd_tgt;
            state_d = FETCH;
          end else begin
            pend_d = rd_tgt;
          end
        end else if (imem_ack) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      default: ;
    endcase
  end

  // Flush strobes: ID/EX for one cycle on any accepted redirect; IF/ID via a
  // reloadable down-counter, legal redirects only.
  always_comb begin
    idex_d = rd_take;
    if (rd_ok)            fcnt_d = 3'(FLUSH_CYC);
    else if (rd_bad)      fcnt_d = '0;
    else if (fcnt_q != 0) fcnt_d = fcnt_q - 3'd1;
    else                  fcnt_d = '0;
  end

  // Outputs
  always_comb begin
    imem_req     = (state_q == FETCH) || (state_q == DRAIN);
    imem_addr    = pc_q;
    cur_pc       = (state_q == DRAIN) ? pend_q : pc_q;
    if_valid     = (state_q == FETCH) && imem_ack && !stall && !redirect_valid;
    flush_ifid   = (fcnt_q != 3'd0);
    flush_idex   = idex_q;
    misalign_err = err_q;
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
  localparam int PC_W      = 9;
  localparam int FLUSH_CYC = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            imem_req, imem_ack, stall, redirect_valid, if_valid;
  logic            flush_ifid, flush_idex, misalign_err;
  logic [PC_W-1:0] imem_addr, cur_pc;
  logic [31:0]     redirect_pc;

  pc_fetch_sequencer #(.PC_W(PC_W), .RESET_PC('0), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .cur_pc(cur_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model, in terms of what the fetch front end is doing:
  // booted/dead lifecycle, whether the next ack must be thrown away and
  // where to go afterwards, and how many flush cycles remain.
  bit m_boot, m_dead, m_drain, m_doom, m_idex, m_err;
  int m_pc, m_tgt, m_ifid;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < (1 << PC_W));
  endfunction

  task automatic model_reset();
    m_boot = 0; m_dead = 0; m_drain = 0; m_doom = 0;
    m_idex = 0; m_err = 0; m_pc = 0; m_tgt = 0; m_ifid = 0;
  endtask

  task automatic model_step(input bit a, input bit s, input bit rv, input logic [31:0] rpc);
    int nifid = (m_ifid > 0) ? m_ifid - 1 : 0;
    bit nidex = 0;
    bit ok    = legal(rpc);
    if (!m_boot) begin
      m_boot = 1;
      if (rv) begin
        nidex = 1;
        if (ok) begin m_pc = int'(rpc); nifid = FLUSH_CYC; end
        else begin m_err = 1; m_dead = 1; nifid = 0; end
      end
    end else if (m_dead) begin
    end else if (m_doom) begin
      if (a) begin m_dead = 1; m_drain = 0; m_doom = 0; end
    end else if (rv) begin
      nidex = 1;
      if (ok) begin
        nifid = FLUSH_CYC;
        if (!a) begin m_drain = 1; m_tgt = int'(rpc); end
        else begin m_pc = int'(rpc); m_drain = 0; end
      end else begin
        m_err = 1; nifid = 0;
        if (m_drain && !a) m_doom = 1;
        else begin m_dead = 1; m_drain = 0; end
      end
    end else if (m_drain) begin
      if (a) begin m_pc = m_tgt; m_drain = 0; end
    end else if (a && !s) begin
      m_pc = (m_pc + 4) % (1 << PC_W);
    end
    m_ifid = nifid;
    m_idex = nidex;
  endtask

  task automatic check_outs(input bit a, input bit s, input bit rv);
    bit live = m_boot && !m_dead;
    chk("imem_req", 32'(imem_req), 32'(live));
    if (live) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("cur_pc", 32'(cur_pc), 32'(m_drain ? m_tgt : m_pc));
    chk("if_valid", 32'(if_valid), 32'(live && !m_drain && a && !s && !rv));
    chk("flush_ifid", 32'(flush_ifid), 32'(m_ifid > 0));
    chk("flush_idex", 32'(flush_idex), 32'(m_idex));
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
  endtask

  task automatic cyc(input bit a, input bit s, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    imem_ack = a; stall = s; redirect_valid = rv; redirect_pc = rpc;
    #1 check_outs(a, s, rv);
    @(posedge clk);
    model_step(a, s, rv, rpc);
  endtask

  // Reset asserted mid-low-phase: outputs must clear with no clock edge.
  task automatic do_reset();
    @(negedge clk);
    imem_ack = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2 reset = 1'b0;
    model_reset();
    #1 check_outs(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic rnd_cyc();
    bit a  = ($urandom_range(0, 9) < 6);
    bit s  = ($urandom_range(0, 3) == 0);
    bit rv = ($urandom_range(0, 9) == 0);
    logic [31:0] rpc;
    int k = $urandom_range(0, 39);
    if (k == 0)      rpc = 32'($urandom_range(0, 511)) | 32'd1;
    else if (k == 1) rpc = 32'($urandom_range(1, 3)) << PC_W;
    else             rpc = 32'($urandom_range(0, 127)) << 2;
    cyc(a, s, rv, rpc);
  endtask

  initial begin
    imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    do_reset();
    // Straight-line fetch through the 0x1FC -> 0x000 wrap.
    repeat (131) cyc(1, 0, 0, 0);
    // Stall with ack at 0x010.
    do_reset();
    repeat (5) cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    // Redirect to 0x040 while 0x020 is unacked, ack two cycles later.
    cyc(0, 0, 1, 32'h40);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    // Redirect with ack and stall together.
    cyc(1, 1, 1, 32'h80);
    repeat (2) cyc(1, 0, 0, 0);
    // Back-to-back redirects reload the flush counter.
    cyc(1, 0, 1, 32'h10);
    cyc(1, 0, 1, 32'h20);
    repeat (3) cyc(1, 0, 0, 0);
    // Misaligned target, sticky until reset.
    cyc(0, 0, 1, 32'h42);
    repeat (3) cyc(1, 0, 1, 32'h40);
    do_reset();
    // Target beyond PC_W.
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'h200);
    repeat (2) cyc(1, 0, 0, 0);
    do_reset();
    // Illegal redirect while draining waits for the ack.
    repeat (2) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h40);
    cyc(0, 0, 1, 32'h41);
    cyc(0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    do_reset();
    // Asynchronous reset mid-DRAIN, then restart from RESET_PC.
    repeat (2) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0);
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else rnd_cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
